mac_pool_engine: RTL and testbench

Streaming, parametrised successor to the combinational 25-tap dot-product and 2x2 max-pool units of the MNIST accelerator. It accepts a vector as a sequence of LANES-wide beats under a valid/ready handshake. In dot mode it accumulates signed products; in max mode it tracks the running maximum. On the last beat it emits one shifted, saturated, optionally ReLU'd IntSize result. It sits between the window/line-buffer feeder and the feature-map writer, replacing one dotProduct plus one maxPool2x2 per channel.

---
 rtl/mac_pool_engine.sv | 168 ++++++++++++++++
 tb/tb_mac_pool_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pool_engine.sv
// Streaming dot-product / max-pool engine: accumulates LANES-wide beats into one
// shifted, saturated, optionally ReLU'd IntSize result per vector.
module mac_pool_engine #(
    parameter int unsigned LANES    = 5,
    parameter int unsigned IntSize  = 8,
    parameter int unsigned AccSize  = 24,
    parameter int unsigned MaxBeats = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_mode,
    input  logic                       i_relu_en,
    input  logic [$clog2(AccSize)-1:0] i_shift,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic                       i_in_last,
    input  logic [LANES*IntSize-1:0]   i_in1,
    input  logic [LANES*IntSize-1:0]   i_in2,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [IntSize-1:0]         o_out,
    output logic                       o_len_err,
    output logic                       o_busy
);

    localparam int unsigned ShW   = $clog2(AccSize);
    localparam int unsigned CntW  = $clog2(MaxBeats + 1);
    localparam int unsigned ProdW = 2 * IntSize;
    localparam logic signed [AccSize-1:0] SatMax = AccSize'((1 << (IntSize - 1)) - 1);
    localparam logic signed [AccSize-1:0] SatMin = ~SatMax;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_mode;
    logic                       r_relu;
    logic [ShW-1:0]             r_shift;
    logic signed [AccSize-1:0]  r_acc;
    logic signed [IntSize-1:0]  r_max;
    logic [CntW-1:0]            r_cnt;
    logic [IntSize-1:0]         r_out;
    logic                       r_out_valid;
    logic                       r_len_err;
    logic                       r_busy;

    logic signed [IntSize-1:0]  w_a;
    logic signed [IntSize-1:0]  w_b;
    logic signed [ProdW-1:0]    w_prod;
    logic signed [AccSize-1:0]  w_prod_sum;
    logic signed [IntSize-1:0]  w_lane_max;
    logic                       w_accept;
    logic                       w_first;
    logic                       w_mode;
    logic                       w_relu;
    logic [ShW-1:0]             w_shift;
    logic signed [AccSize-1:0]  w_acc_next;
    logic signed [IntSize-1:0]  w_max_next;
    logic [CntW-1:0]            w_cnt_next;
    logic                       w_at_max;
    logic                       w_end;
    logic                       w_len_err;
    logic signed [AccSize-1:0]  w_shifted;
    logic signed [IntSize-1:0]  w_res;

    // Per-beat lane reduction: sum of signed products and max of data lanes.
    always_comb begin
        w_a        = '0;
        w_b        = '0;
        w_prod     = '0;
        w_prod_sum = '0;
        w_lane_max = $signed(i_in1[IntSize-1:0]);
        for (int k = 0; k < int'(LANES); k++) begin
            w_a        = $signed(i_in1[k*IntSize +: IntSize]);
            w_b        = $signed(i_in2[k*IntSize +: IntSize]);
            w_prod     = w_a * w_b;
            w_prod_sum = w_prod_sum + AccSize'(w_prod);
            if (w_a > w_lane_max) begin
                w_lane_max = w_a;
            end
        end
    end

    assign o_in_ready = !r_out_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_first    = (r_state == ST_IDLE);

    // Configuration comes straight from the ports on the first beat, from the latch afterwards.
    assign w_mode     = w_first ? i_mode    : r_mode;
    assign w_relu     = w_first ? i_relu_en : r_relu;
    assign w_shift    = w_first ? i_shift   : r_shift;
    assign w_acc_next = w_first ? w_prod_sum : r_acc + w_prod_sum;
    assign w_max_next = (w_first || (w_lane_max > r_max)) ? w_lane_max : r_max;
    assign w_cnt_next = w_first ? CntW'(1) : r_cnt + CntW'(1);
    assign w_at_max   = (w_cnt_next == CntW'(MaxBeats));
    assign w_end      = w_accept && (i_in_last || w_at_max);
    assign w_len_err  = w_at_max && !i_in_last;
    assign w_shifted  = w_acc_next >>> w_shift;

    always_comb begin
        w_res = '0;
        if (w_mode) begin
            w_res = w_max_next;
        end else if (w_shifted > SatMax) begin
            w_res = {1'b0, {(IntSize-1){1'b1}}};
        end else if (w_shifted < SatMin) begin
            w_res = {1'b1, {(IntSize-1){1'b0}}};
        end else begin
            w_res = w_shifted[IntSize-1:0];
        end
        if (w_relu && w_res[IntSize-1]) begin
            w_res = '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_end ? ST_IDLE : ST_ACCUM;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_mode      <= 1'b0;
            r_relu      <= 1'b0;
            r_shift     <= '0;
            r_acc       <= '0;
            r_max       <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_ACCUM);
            if (w_accept) begin
                if (w_first) begin
                    r_mode  <= i_mode;
                    r_relu  <= i_relu_en;
                    r_shift <= i_shift;
                end
                r_acc <= w_acc_next;
                r_max <= w_max_next;
                r_cnt <= w_end ? '0 : w_cnt_next;
            end
            // A load always wins over a consume: w_end implies the slot is free or draining.
            if (w_end) begin
                r_out       <= w_res;
                r_out_valid <= 1'b1;
                r_len_err   <= w_len_err;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_len_err   = r_len_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mac_pool_engine.sv
// Directed bench for mac_pool_engine: table of vectors plus stall/length and reset sequences.
module tb_mac_pool_engine;

    localparam int unsigned W = 40;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_mode;
    logic          i_relu_en;
    logic [4:0]    i_shift;
    logic          i_in_valid;
    logic          o_in_ready;
    logic          i_in_last;
    logic [W-1:0]  i_in1;
    logic [W-1:0]  i_in2;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [7:0]    o_out;
    logic          o_len_err;
    logic          o_busy;

    int checks   = 0;
    int failures = 0;

    mac_pool_engine dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_mode     (i_mode),
        .i_relu_en  (i_relu_en),
        .i_shift    (i_shift),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_last  (i_in_last),
        .i_in1      (i_in1),
        .i_in2      (i_in2),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_out      (o_out),
        .o_len_err  (o_len_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             mode;
        logic             relu;
        int               shift;
        int               nbeats;
        logic             last_on;
        logic [4:0][39:0] in1;
        logic [4:0][39:0] in2;
        int               exp_out;
        logic             exp_len;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {e[7:0], d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [39:0] splat(input int v);
        return pk(v, v, v, v, v);
    endfunction

    function automatic logic [39:0] rnd();
        return pk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
    endfunction

    function automatic vec_t mk(input logic m, input logic r, input int sh, input int nb,
                                input logic lst, input int eo, input logic el);
        vec_t v;
        v.mode = m; v.relu = r; v.shift = sh; v.nbeats = nb; v.last_on = lst;
        v.exp_out = eo; v.exp_len = el;
        for (int i = 0; i < 5; i++) begin
            v.in1[i] = '0;
            v.in2[i] = '0;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [39:0] a, input logic [39:0] b, input logic last);
        i_in1      = a;
        i_in2      = b;
        i_in_last  = last;
        i_in_valid = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    // Later beats drive deliberately wrong configuration to show it is latched on beat 1.
    task automatic run_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        for (int b = 0; b < v.nbeats; b++) begin
            chk($sformatf("v%0d_in_ready_b%0d", idx, b), int'(o_in_ready), 1);
            if (b == 0) begin
                i_mode    = v.mode;
                i_relu_en = v.relu;
                i_shift   = 5'(v.shift);
            end else begin
                i_mode    = ~v.mode;
                i_relu_en = ~v.relu;
                i_shift   = 5'(v.shift + 7);
            end
            drive_beat(v.in1[b], v.in2[b], v.last_on && (b == v.nbeats - 1));
            if (b == 0 && v.nbeats > 1) chk($sformatf("v%0d_busy", idx), int'(o_busy), 1);
        end
        chk($sformatf("v%0d_out_valid", idx), int'(o_out_valid), 1);
        chk($sformatf("v%0d_out", idx), int'($signed(o_out)), v.exp_out);
        chk($sformatf("v%0d_len_err", idx), int'(o_len_err), int'(v.exp_len));
        chk($sformatf("v%0d_busy_end", idx), int'(o_busy), 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid_clear", idx), int'(o_out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(0, 0, 0, 5, 1, 25, 0);
        for (int i = 0; i < 5; i++) begin
            tbl[0].in1[i] = splat(1);
            tbl[0].in2[i] = splat(1);
        end
        tbl[1] = mk(0, 0, 0, 1, 1, 127, 0);
        tbl[1].in1[0] = splat(127); tbl[1].in2[0] = splat(127);
        tbl[2] = mk(0, 0, 10, 1, 1, 78, 0);
        tbl[2].in1[0] = splat(127); tbl[2].in2[0] = splat(127);
        tbl[3] = mk(0, 0, 10, 1, 1, -80, 0);
        tbl[3].in1[0] = splat(-128); tbl[3].in2[0] = splat(127);
        tbl[4] = mk(0, 1, 10, 1, 1, 0, 0);
        tbl[4].in1[0] = splat(-128); tbl[4].in2[0] = splat(127);
        tbl[5] = mk(1, 0, 0, 2, 1, -2, 0);
        tbl[5].in1[0] = pk(-3, -7, -9, -4, -5);   tbl[5].in2[0] = rnd();
        tbl[5].in1[1] = pk(-6, -2, -8, -10, -11); tbl[5].in2[1] = rnd();
        tbl[6] = tbl[5];
        tbl[6].relu = 1; tbl[6].exp_out = 0;
        tbl[7] = mk(1, 0, 3, 2, 1, 100, 0);
        tbl[7].in1[0] = pk(3, -7, 100, -4, 5);  tbl[7].in2[0] = rnd();
        tbl[7].in1[1] = pk(-6, 2, 8, -10, 11);  tbl[7].in2[1] = rnd();
        tbl[8] = mk(0, 0, 1, 2, 1, 7, 0);
        tbl[8].in1[0] = pk(1, 2, 3, 4, 5);      tbl[8].in2[0] = splat(-1);
        tbl[8].in1[1] = pk(10, 0, 0, 0, 0);     tbl[8].in2[1] = splat(3);
        tbl[9] = mk(0, 0, 1, 1, 1, -8, 0);
        tbl[9].in1[0] = pk(1, 2, 3, 4, 5);      tbl[9].in2[0] = splat(-1);
        tbl[10] = mk(0, 0, 0, 1, 1, -128, 0);
        tbl[10].in1[0] = splat(-128); tbl[10].in2[0] = splat(127);
        tbl[11] = tbl[0];
        tbl[11].last_on = 0; tbl[11].exp_len = 1;

        i_rst = 1'b1; i_mode = 1'b0; i_relu_en = 1'b0; i_shift = '0;
        i_in_valid = 1'b0; i_in_last = 1'b0; i_in1 = '0; i_in2 = '0; i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(o_in_ready), 1);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        chk("rst_out_valid", int'(o_out_valid), 0);
        chk("rst_out", int'(o_out), 0);
        chk("rst_len_err", int'(o_len_err), 0);
        chk("rst_busy", int'(o_busy), 0);

        for (int i = 0; i < 12; i++) run_vec(i);

        // Stall: result 30 held while a new beat waits, then a 6-beat vector with no last.
        i_out_ready = 1'b0;
        i_mode = 1'b0; i_relu_en = 1'b0; i_shift = '0;
        drive_beat(splat(2), splat(3), 1'b1);
        chk("stall_first_valid", int'(o_out_valid), 1);
        chk("stall_first_out", int'($signed(o_out)), 30);
        i_in1 = splat(1); i_in2 = splat(1); i_in_last = 1'b0; i_in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_in_ready_c%0d", c), int'(o_in_ready), 0);
            chk($sformatf("stall_out_c%0d", c), int'($signed(o_out)), 30);
            chk($sformatf("stall_valid_c%0d", c), int'(o_out_valid), 1);
            chk($sformatf("stall_busy_c%0d", c), int'(o_busy), 0);
        end
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        chk("release_valid", int'(o_out_valid), 0);
        chk("release_busy", int'(o_busy), 1);
        for (int b = 1; b < 5; b++) drive_beat(splat(1), splat(1), 1'b0);
        chk("len_valid", int'(o_out_valid), 1);
        chk("len_out", int'($signed(o_out)), 25);
        chk("len_err", int'(o_len_err), 1);
        chk("len_busy", int'(o_busy), 0);
        drive_beat(splat(1), splat(2), 1'b1);
        chk("beat6_valid", int'(o_out_valid), 1);
        chk("beat6_out", int'($signed(o_out)), 10);
        chk("beat6_len_err", int'(o_len_err), 0);
        @(posedge clk);
        #1;

        // Reset after 3 of 5 beats discards the partial vector.
        for (int b = 0; b < 3; b++) drive_beat(splat(1), splat(1), 1'b0);
        chk("pre_rst_busy", int'(o_busy), 1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        chk("mid_rst_out", int'(o_out), 0);
        chk("mid_rst_valid", int'(o_out_valid), 0);
        chk("mid_rst_len_err", int'(o_len_err), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        for (int b = 0; b < 5; b++) begin
            drive_beat(splat(2), splat(2), b == 4);
            if (b < 4) chk($sformatf("post_rst_novalid_b%0d", b), int'(o_out_valid), 0);
        end
        chk("post_rst_valid", int'(o_out_valid), 1);
        chk("post_rst_out", int'($signed(o_out)), 100);
        chk("post_rst_len_err", int'(o_len_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
